rvb_shifter_issue: RTL and testbench
====================================

// Module: rvb_shifter_issue
// PURPOSE
// Issue stage directly upstream of rvb_shifter. Accepts a raw 32-bit instruction plus rs1/rs2/rs3 and
// checks that it is a shifter-class op. It substitutes the immediate shift amount for rs2 on immediate
// forms, extracts the instruction control bits, and presents them registered on rvb_shifter's din_*
// port. A 2-entry skid buffer gives full throughput with a registered in_ready. Illegal ops are dropped.
// PARAMETERS
// XLEN   64  datapath width (32 or 64)
// SBOP   1   accept single-bit ops (SBSET/SBCLR/SBINV/SBEXT); 0 = treat as illegal
// BFP    1   accept BFP (insn12==0); 0 = treat as illegal
// PORTS
// clock        in   1     positive-edge clock
// resetn       in   1     reset, asynchronous, active-low
// flush        in   1     synchronous flush of all buffered entries
// in_valid     in   1     upstream entry valid
// in_ready     out  1     stage can accept (registered)
// in_insn      in   32    raw instruction word
// in_rs1/2/3   in   XLEN  operand values
// dout_valid   out  1     to rvb_shifter din_valid
// dout_ready   in   1     from rvb_shifter din_ready
// dout_rs1/2/3 out  XLEN  to din_rs1/2/3 (rs2 = imm shamt on immediate forms)
// dout_insn3/12/14/26/27/29/30  out 1 each  to matching din_insnN
// drop_pulse   out  1     one-cycle pulse when an illegal entry is consumed
// drop_count   out  16    saturating count of dropped entries
// BEHAVIOUR
// - Reset (resetn low, async): buffer EMPTY, dout_valid=0, in_ready=1, drop_pulse=0, drop_count=0,
//   all dout data 0. Deassertion is taken synchronously; first accept is possible on the next clock edge.
// - Legal = opcode in {OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011};
//   AND (insn12 || (BFP && insn14 && !insn26));
//   AND (XLEN==64 || opcode[3]==0);
//   AND (SBOP || !(insn27 && !insn26 && (insn30||insn29)) || SLLIU.W pattern).
// - Immediate form (opcode[5]==0): dout_rs2 = zero-extended in_insn[25:20] for XLEN=64 and non-W forms,
//   in_insn[24:20] otherwise; bits above 6 are 0. Register forms pass in_rs2 unchanged.
// - Accept occurs when in_valid && in_ready. Illegal accepts never enter the buffer. On the next cycle
//   drop_pulse=1 and drop_count += 1, saturating at 16'hFFFF.
// - States: EMPTY (out reg empty), ONE (out reg full), TWO (out reg + skid full).
//   EMPTY: legal accept -> ONE.
//   ONE:   legal accept and no pop -> TWO; accept+pop -> ONE (new entry into out reg);
//          pop only -> EMPTY.
//   TWO:   in_ready=0; pop -> ONE (skid moves to out reg).
//   Pop = dout_valid && dout_ready.
// - in_ready = (state != TWO), registered; it is never a combinational function of dout_ready.
// - Latency: 1 cycle from accept to dout_valid when empty. Sustained 1 entry/cycle while dout_ready=1.
// - dout_* is stable while dout_valid && !dout_ready. Ordering is strictly FIFO.
// - flush: next state EMPTY and in_ready=1. An in-flight accept in the same cycle is discarded,
//   including an illegal accept (no drop_pulse, counter unchanged). flush has priority over all events.
// - Reset mid-transfer discards all entries; drop_count is cleared.
// STRUCTURE
// - Shared package rvb_pkg: opcode constants (OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32),
//   state encoding (ST_EMPTY/ST_ONE/ST_TWO), and a packed entry typedef {rs1, rs2, rs3, 7 ctrl bits}.
// - One sub-module: rvb_issue_decode (combinational: legality, imm substitution, ctrl extraction).
//   The parent holds the FSM, out reg, skid reg and counter.
// TESTING
// 1 Reset: resetn=0 mid-stream -> dout_valid=0, in_ready=1, drop_count=0 immediately (async).
// 2 SLLI rs1=64'h1, insn[25:20]=6'd40, dout_ready=1 -> next cycle dout_valid=1, dout_rs2=64'd40,
//   dout_insn14=0, dout_insn12=1.
// 3 Back-to-back 8 legal ops, dout_ready held 0 after first -> in_ready drops after 2 accepts;
//   release -> all 8 emerge in order, 1 per cycle.
// 4 Illegal opcode 0000011 (LOAD) -> no dout_valid, drop_pulse=1 one cycle, drop_count=1.
//   With SBOP=0, SBSET -> dropped.
// 5 State TWO, flush with in_valid=1 -> next cycle dout_valid=0, in_ready=1, no drop_pulse.
// 6 Force drop_count=16'hFFFE, send 3 illegal ops -> count 16'hFFFF, stays saturated.

Source files
------------

// File: rtl/rvb_pkg.sv
// Shared types and constants for the bitmanip shifter issue stage.
package rvb_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned INSN_W   = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SHAMT_W  = 6;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Instruction bits consumed by the shifter datapath
    typedef struct packed {
        logic insn3;
        logic insn12;
        logic insn14;
        logic insn26;
        logic insn27;
        logic insn29;
        logic insn30;
    } ctrl_t;

    // Operands are stored at full width; narrower configurations use the low XLEN bits
    typedef struct packed {
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
        logic [XLEN_MAX-1:0] rs3;
        ctrl_t               ctrl;
    } entry_t;

    function automatic ctrl_t ctrl_of(input logic [INSN_W-1:0] insn);
        ctrl_t c;
        c.insn3  = insn[3];
        c.insn12 = insn[12];
        c.insn14 = insn[14];
        c.insn26 = insn[26];
        c.insn27 = insn[27];
        c.insn29 = insn[29];
        c.insn30 = insn[30];
        return c;
    endfunction

endpackage

// File: rtl/rvb_issue_decode.sv
// Combinational decode: shifter-class legality, immediate shamt substitution, ctrl extraction.
module rvb_issue_decode
    import rvb_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter bit          SBOP = 1'b1,
    parameter bit          BFP  = 1'b1
) (
    input  logic [INSN_W-1:0] insn,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   rs3,
    output logic              legal_c,
    output entry_t            entry_c
);

    logic [6:0]         opcode;
    logic               opc_ok;
    logic               funct_ok;
    logic               width_ok;
    logic               is_sb;
    logic               is_slliu_w;
    logic               sbop_ok;
    logic               imm_form;
    logic               wide_shamt;
    logic [SHAMT_W-1:0] shamt;
    logic               unused_insn;

    assign opcode      = insn[6:0];
    assign unused_insn = ^{insn[19:15], insn[11:7]};

    always_comb begin
        opc_ok     = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
        funct_ok   = insn[12] || (BFP && insn[14] && !insn[26]);
        width_ok   = (XLEN == 64) || !opcode[3];
        is_sb      = insn[27] && !insn[26] && (insn[30] || insn[29]);
        is_slliu_w = (opcode == OPC_OP_IMM_32) && (insn[31:26] == 6'b000010) &&
                     (insn[14:12] == 3'b001);
        sbop_ok    = SBOP || !is_sb || is_slliu_w;
        legal_c    = opc_ok && funct_ok && width_ok && sbop_ok;
    end

    // W forms and RV32 only have a 5-bit shift amount
    always_comb begin
        imm_form   = !opcode[5];
        wide_shamt = (XLEN == 64) && !opcode[3];
        shamt      = wide_shamt ? insn[25:20] : {1'b0, insn[24:20]};
    end

    always_comb begin
        entry_c      = '0;
        entry_c.rs1  = XLEN_MAX'(rs1);
        entry_c.rs2  = imm_form ? XLEN_MAX'(shamt) : XLEN_MAX'(rs2);
        entry_c.rs3  = XLEN_MAX'(rs3);
        entry_c.ctrl = ctrl_of(insn);
    end

endmodule

// File: rtl/rvb_shifter_issue.sv
// Issue stage in front of rvb_shifter: decode, 2-entry skid buffer, illegal-op drop counter.
module rvb_shifter_issue
    import rvb_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter bit          SBOP = 1'b1,
    parameter bit          BFP  = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_rs3,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [XLEN-1:0]   dout_rs1,
    output logic [XLEN-1:0]   dout_rs2,
    output logic [XLEN-1:0]   dout_rs3,
    output logic              dout_insn3,
    output logic              dout_insn12,
    output logic              dout_insn14,
    output logic              dout_insn26,
    output logic              dout_insn27,
    output logic              dout_insn29,
    output logic              dout_insn30,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count
);

    state_t             state;
    state_t             state_nxt;
    entry_t             out_q;
    entry_t             out_nxt;
    entry_t             skid_q;
    entry_t             skid_nxt;
    entry_t             entry_c;
    logic               legal_c;
    logic               accept;
    logic               pop;
    logic               acc_legal;
    logic               acc_illegal;
    logic               drop_nxt;
    logic [CNT_W-1:0]   count_nxt;

    rvb_issue_decode #(
        .XLEN (XLEN),
        .SBOP (SBOP),
        .BFP  (BFP)
    ) u_decode (
        .insn    (in_insn),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .rs3     (in_rs3),
        .legal_c (legal_c),
        .entry_c (entry_c)
    );

    assign accept      = in_valid && in_ready;
    assign pop         = dout_valid && dout_ready;
    assign acc_legal   = accept && legal_c;
    assign acc_illegal = accept && !legal_c;

    // Next state, buffer contents and drop accounting; flush overrides every event
    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        skid_nxt  = skid_q;
        drop_nxt  = 1'b0;
        count_nxt = drop_count;
        if (!flush) begin
            case (state)
                ST_EMPTY: begin
                    if (acc_legal) begin
                        state_nxt = ST_ONE;
                        out_nxt   = entry_c;
                    end
                end
                ST_ONE: begin
                    if (acc_legal && pop) begin
                        out_nxt = entry_c;
                    end else if (acc_legal) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = entry_c;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        out_nxt   = skid_q;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
            if (acc_illegal) begin
                drop_nxt = 1'b1;
                if (drop_count != '1) begin
                    count_nxt = drop_count + CNT_W'(1);
                end
            end
        end else begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_EMPTY;
            in_ready   <= 1'b1;
            dout_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            in_ready   <= (state_nxt != ST_TWO);
            dout_valid <= (state_nxt != ST_EMPTY);
            out_q      <= out_nxt;
            skid_q     <= skid_nxt;
            drop_pulse <= drop_nxt;
            drop_count <= count_nxt;
        end
    end

    assign dout_rs1    = out_q.rs1[XLEN-1:0];
    assign dout_rs2    = out_q.rs2[XLEN-1:0];
    assign dout_rs3    = out_q.rs3[XLEN-1:0];
    assign dout_insn3  = out_q.ctrl.insn3;
    assign dout_insn12 = out_q.ctrl.insn12;
    assign dout_insn14 = out_q.ctrl.insn14;
    assign dout_insn26 = out_q.ctrl.insn26;
    assign dout_insn27 = out_q.ctrl.insn27;
    assign dout_insn29 = out_q.ctrl.insn29;
    assign dout_insn30 = out_q.ctrl.insn30;

endmodule

// File: tb/tb_rvb_shifter_issue.sv
// Directed bench for rvb_shifter_issue; a second instance with SBOP=0 checks single-bit op rejection.
module tb_rvb_shifter_issue;
    import rvb_pkg::*;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [63:0] in_rs1, in_rs2, in_rs3;
    logic        dout_ready;

    logic        in_ready, dout_valid, drop_pulse;
    logic [63:0] dout_rs1, dout_rs2, dout_rs3;
    logic        dout_insn3, dout_insn12, dout_insn14, dout_insn26, dout_insn27, dout_insn29, dout_insn30;
    logic [15:0] drop_count;

    logic        n_in_ready, n_dout_valid, n_drop_pulse;
    logic [63:0] n_rs1, n_rs2, n_rs3;
    logic        n_i3, n_i12, n_i14, n_i26, n_i27, n_i29, n_i30;
    logic [15:0] n_drop_count;

    int n_cmp = 0;
    int n_err = 0;

    rvb_shifter_issue #(.XLEN(64), .SBOP(1'b1), .BFP(1'b1)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_rs1(dout_rs1), .dout_rs2(dout_rs2), .dout_rs3(dout_rs3),
        .dout_insn3(dout_insn3), .dout_insn12(dout_insn12), .dout_insn14(dout_insn14),
        .dout_insn26(dout_insn26), .dout_insn27(dout_insn27), .dout_insn29(dout_insn29),
        .dout_insn30(dout_insn30), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    rvb_shifter_issue #(.XLEN(64), .SBOP(1'b0), .BFP(1'b1)) dut_nosb (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_insn(in_insn),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .dout_valid(n_dout_valid), .dout_ready(dout_ready),
        .dout_rs1(n_rs1), .dout_rs2(n_rs2), .dout_rs3(n_rs3),
        .dout_insn3(n_i3), .dout_insn12(n_i12), .dout_insn14(n_i14),
        .dout_insn26(n_i26), .dout_insn27(n_i27), .dout_insn29(n_i29),
        .dout_insn30(n_i30), .drop_pulse(n_drop_pulse), .drop_count(n_drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] lo,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {f7, lo, 5'd1, f3, 5'd2, opc};
    endfunction

    // Register-form SLL carrying a recognisable operand pattern
    task automatic drive_op(input int i);
        in_insn = mk(7'd0, 5'd5, 3'b001, OPC_OP);
        in_rs1  = 64'h10 + 64'(i);
        in_rs2  = 64'h100 + 64'(i);
        in_rs3  = 64'h200 + 64'(i);
    endtask

    localparam logic [31:0] LOAD = 32'h0000_2083;

    initial begin
        int  nin;
        logic acc;
        resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; dout_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_valid", dout_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_count", drop_count, 16'd0);
        check("rst_pulse", drop_pulse, 1'b0);
        step(); step();
        resetn = 1'b1;
        step();

        // SLLI with 6-bit shamt 40 substitutes the immediate for rs2
        in_valid = 1'b1; in_insn = mk(7'b0000001, 5'd8, 3'b001, OPC_OP_IMM);
        in_rs1 = 64'h1; in_rs2 = 64'hdead; in_rs3 = 64'h3;
        step();
        in_valid = 1'b0;
        check("slli_valid", dout_valid, 1'b1);
        check("slli_rs1", dout_rs1, 64'h1);
        check("slli_rs2", dout_rs2, 64'd40);
        check("slli_i14", dout_insn14, 1'b0);
        check("slli_i12", dout_insn12, 1'b1);
        check("slli_i3", dout_insn3, 1'b0);
        step();
        check("slli_popped", dout_valid, 1'b0);

        // W form only uses insn[24:20]
        in_valid = 1'b1; in_insn = mk(7'b0000001, 5'd3, 3'b001, OPC_OP_IMM_32);
        step();
        in_valid = 1'b0;
        check("slliw_rs2", dout_rs2, 64'd3);
        check("slliw_i3", dout_insn3, 1'b1);
        step();

        // Eight back-to-back ops with a stalled consumer
        dout_ready = 1'b0;
        in_valid = 1'b1; drive_op(0);
        step();
        check("bb_valid0", dout_valid, 1'b1);
        check("bb_ready0", in_ready, 1'b1);
        drive_op(1);
        step();
        check("bb_ready_full", in_ready, 1'b0);
        drive_op(2);
        for (int k = 0; k < 2; k++) begin
            step();
            check("bb_hold_ready", in_ready, 1'b0);
            check("bb_hold_rs1", dout_rs1, 64'h10);
        end
        dout_ready = 1'b1;
        nin = 2;
        for (int k = 0; k < 8; k++) begin
            check("bb_out_valid", dout_valid, 1'b1);
            check("bb_out_rs1", dout_rs1, 64'h10 + 64'(k));
            check("bb_out_rs3", dout_rs3, 64'h200 + 64'(k));
            acc = in_valid && in_ready;
            step();
            if (acc) nin++;
            in_valid = (nin < 8);
            drive_op(nin);
        end
        in_valid = 1'b0;
        check("bb_drained", dout_valid, 1'b0);
        check("bb_ready_end", in_ready, 1'b1);

        // Illegal LOAD is dropped
        in_valid = 1'b1; in_insn = LOAD;
        step();
        in_valid = 1'b0;
        check("ld_valid", dout_valid, 1'b0);
        check("ld_pulse", drop_pulse, 1'b1);
        check("ld_count", drop_count, 16'd1);
        step();
        check("ld_pulse_end", drop_pulse, 1'b0);

        // SBSET: legal with SBOP=1, dropped with SBOP=0
        in_valid = 1'b1; in_insn = mk(7'b0010100, 5'd4, 3'b001, OPC_OP);
        in_rs2 = 64'h77;
        step();
        in_valid = 1'b0;
        check("sb_valid", dout_valid, 1'b1);
        check("sb_rs2", dout_rs2, 64'h77);
        check("sb_i29", dout_insn29, 1'b1);
        check("sb_i27", dout_insn27, 1'b1);
        check("sb_pulse", drop_pulse, 1'b0);
        check("nosb_pulse", n_drop_pulse, 1'b1);
        check("nosb_count", n_drop_count, 16'd2);
        check("nosb_valid", n_dout_valid, 1'b0);
        step();

        // insn12=0 is legal only as BFP (insn14=1, insn26=0)
        in_valid = 1'b1; in_insn = mk(7'd0, 5'd1, 3'b100, OPC_OP);
        step();
        in_valid = 1'b0;
        check("bfp_valid", dout_valid, 1'b1);
        check("bfp_i14", dout_insn14, 1'b1);
        check("bfp_i12", dout_insn12, 1'b0);
        step();
        in_valid = 1'b1; in_insn = mk(7'b0000010, 5'd1, 3'b100, OPC_OP);
        step();
        in_valid = 1'b0;
        check("bfp26_valid", dout_valid, 1'b0);
        check("bfp26_count", drop_count, 16'd2);
        step();

        // Flush from TWO with input still valid
        dout_ready = 1'b0;
        in_valid = 1'b1; drive_op(0);
        step();
        drive_op(1);
        step();
        check("fl_full", in_ready, 1'b0);
        flush = 1'b1; drive_op(2);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", dout_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        check("fl_pulse", drop_pulse, 1'b0);
        in_valid = 1'b1; in_insn = LOAD; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_ill_pulse", drop_pulse, 1'b0);
        check("fl_ill_count", drop_count, 16'd2);
        check("fl_ill_valid", dout_valid, 1'b0);

        // Asynchronous reset mid-transfer
        in_valid = 1'b1; drive_op(5);
        step();
        in_valid = 1'b0;
        check("mr_pre_valid", dout_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("mr_valid", dout_valid, 1'b0);
        check("mr_ready", in_ready, 1'b1);
        check("mr_count", drop_count, 16'd0);
        check("mr_rs1", dout_rs1, 64'h0);
        step();
        resetn = 1'b1;
        dout_ready = 1'b1;
        step();

        // Drive the counter to saturation
        in_valid = 1'b1; in_insn = LOAD;
        repeat (65534) @(posedge clock);
        #1;
        check("sat_fffe", drop_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sat_ffff", drop_count, 16'hFFFF);
            check("sat_pulse", drop_pulse, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("sat_hold", drop_count, 16'hFFFF);
        check("sat_pulse_end", drop_pulse, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
